// File: rtl/hslp_pkg.sv
// Shared definitions for the sequential nibble multiplier: FSM encoding,
// per-step shift amounts and step-scheduling helpers.
package hslp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LL   = 3'd1,
        ST_LH   = 3'd2,
        ST_HL   = 3'd3,
        ST_HH   = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    localparam logic [3:0] SH_LL = 4'd0;
    localparam logic [3:0] SH_LH = 4'd4;
    localparam logic [3:0] SH_HL = 4'd4;
    localparam logic [3:0] SH_HH = 4'd8;

    // Bit k set means step k (LL, LH, HL, HH) must execute.
    function automatic logic [3:0] run_mask(input logic [7:0] x, input logic [7:0] y,
                                            input logic zero_skip);
        logic [3:0] m;
        m[0] = (x[3:0] != 4'd0) && (y[3:0] != 4'd0);
        m[1] = (x[3:0] != 4'd0) && (y[7:4] != 4'd0);
        m[2] = (x[7:4] != 4'd0) && (y[3:0] != 4'd0);
        m[3] = (x[7:4] != 4'd0) && (y[7:4] != 4'd0);
        return zero_skip ? m : 4'hF;
    endfunction

    // First executing step with index >= from, or DONE if none remain.
    function automatic state_t next_step(input logic [3:0] mask, input int from);
        state_t nxt;
        nxt = ST_DONE;
        for (int k = 3; k >= 0; k--) begin
            if (k >= from && mask[k]) nxt = state_t'(3'(k + 1));
        end
        return nxt;
    endfunction

endpackage

// File: rtl/hslp_seq_mul_ap4.sv
// 4x4 approximate multiplier: exact for partial-product columns of weight >= 4,
// the two least-significant columns are combined with OR and drop their carry.
module hslp_seq_mul_ap4 (
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic [7:0] p
);

    logic [7:0] hi;

    always_comb begin
        hi = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (i + j >= 2) hi = hi + (8'(x[i] & y[j]) << (i + j));
            end
        end
    end

    assign p = {hi[7:2], (x[1] & y[0]) | (x[0] & y[1]), x[0] & y[0]};

endmodule

// File: rtl/hslp_seq_mul.sv
// Sequential 8x8 approximate multiplier reusing one ap4 core over four nibble steps,
// optionally skipping steps whose nibble pair contains a zero.
//
// state | meaning
// IDLE  | waiting for an operand pair (in_ready high)
// LL    | accumulate ap4(a_lo, b_lo)
// LH    | accumulate ap4(a_lo, b_hi) << 4
// HL    | accumulate ap4(a_hi, b_lo) << 4
// HH    | accumulate ap4(a_hi, b_hi) << 8
// DONE  | result presented on prod until out_ready
module hslp_seq_mul
    import hslp_pkg::*;
#(
    parameter bit ZERO_SKIP = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] prod,
    output logic        busy
);

    state_t      state_q, state_d;
    logic [7:0]  op_a, op_b;
    logic [15:0] acc;
    logic [3:0]  nib_x, nib_y, shamt;
    logic [7:0]  pp;
    logic        step_en, xfer;
    logic [3:0]  mask_in, mask_op;

    assign xfer    = in_valid && (state_q == ST_IDLE);
    assign mask_in = run_mask(a, b, ZERO_SKIP);
    assign mask_op = run_mask(op_a, op_b, ZERO_SKIP);

    always_comb begin
        nib_x   = op_a[3:0];
        nib_y   = op_b[3:0];
        shamt   = SH_LL;
        step_en = 1'b0;
        case (state_q)
            ST_LL: begin
                step_en = 1'b1;
            end
            ST_LH: begin
                nib_y   = op_b[7:4];
                shamt   = SH_LH;
                step_en = 1'b1;
            end
            ST_HL: begin
                nib_x   = op_a[7:4];
                shamt   = SH_HL;
                step_en = 1'b1;
            end
            ST_HH: begin
                nib_x   = op_a[7:4];
                nib_y   = op_b[7:4];
                shamt   = SH_HH;
                step_en = 1'b1;
            end
            default: ;
        endcase
    end

    hslp_seq_mul_ap4 u_ap4 (
        .x (nib_x),
        .y (nib_y),
        .p (pp)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid) state_d = next_step(mask_in, 0);
            ST_LL:   state_d = next_step(mask_op, 1);
            ST_LH:   state_d = next_step(mask_op, 2);
            ST_HL:   state_d = next_step(mask_op, 3);
            ST_HH:   state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_a    <= '0;
            op_b    <= '0;
            acc     <= '0;
        end else begin
            state_q <= state_d;
            if (xfer) begin
                op_a <= a;
                op_b <= b;
                acc  <= '0;
            end else if (step_en) begin
                acc <= acc + (16'(pp) << shamt);
            end
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign prod      = out_valid ? acc : 16'h0000;

endmodule

// File: tb/tb_hslp_seq_mul.sv
// Self-checking bench: two instances (zero-skip on/off), a vector table with
// expected latencies, a result scoreboard, and hand-written backpressure/reset runs.
module tb_hslp_seq_mul;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid_s, in_ready_s, out_valid_s, out_ready_s, busy_s;
    logic        in_valid_n, in_ready_n, out_valid_n, out_ready_n, busy_n;
    logic [7:0]  a_s, b_s, a_n, b_n;
    logic [15:0] prod_s, prod_n;

    int checks = 0;
    int errors = 0;

    logic [15:0] q_s[$];
    logic [15:0] q_n[$];

    always #5 clk = ~clk;

    hslp_seq_mul #(.ZERO_SKIP(1'b1)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid_s), .in_ready(in_ready_s),
        .a(a_s), .b(b_s), .out_valid(out_valid_s), .out_ready(out_ready_s),
        .prod(prod_s), .busy(busy_s)
    );

    hslp_seq_mul #(.ZERO_SKIP(1'b0)) dut_n (
        .clk(clk), .rst(rst), .in_valid(in_valid_n), .in_ready(in_ready_n),
        .a(a_n), .b(b_n), .out_valid(out_valid_n), .out_ready(out_ready_n),
        .prod(prod_n), .busy(busy_n)
    );

    function automatic int ap4_model(input int x, input int y);
        int x0, x1, y0, y1, upper;
        x0 = x & 1; x1 = (x >> 1) & 1;
        y0 = y & 1; y1 = (y >> 1) & 1;
        upper = x * y - (x0 * y0) - 2 * (x1 * y0 + x0 * y1);
        return upper | (((x1 & y0) | (x0 & y1)) << 1) | (x0 & y0);
    endfunction

    function automatic logic [15:0] mul_model(input logic [7:0] av, input logic [7:0] bv,
                                              input bit zs);
        int al, ah, bl, bh, sum;
        al = int'(av[3:0]); ah = int'(av[7:4]);
        bl = int'(bv[3:0]); bh = int'(bv[7:4]);
        sum = 0;
        if (!zs || (al != 0 && bl != 0)) sum += ap4_model(al, bl);
        if (!zs || (al != 0 && bh != 0)) sum += ap4_model(al, bh) * 16;
        if (!zs || (ah != 0 && bl != 0)) sum += ap4_model(ah, bl) * 16;
        if (!zs || (ah != 0 && bh != 0)) sum += ap4_model(ah, bh) * 256;
        return 16'(sum);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Scoreboard: predict at transfer, compare at the output handshake.
    always @(negedge clk) begin
        if (rst) begin
            q_s.delete();
            q_n.delete();
        end else begin
            if (in_valid_s && in_ready_s) q_s.push_back(mul_model(a_s, b_s, 1'b1));
            if (in_valid_n && in_ready_n) q_n.push_back(mul_model(a_n, b_n, 1'b0));
            if (out_valid_s && out_ready_s) begin
                if (q_s.size() == 0) check("sb_s_unexpected", 1, 0);
                else check("sb_s_prod", 32'(prod_s), 32'(q_s.pop_front()));
            end
            if (out_valid_n && out_ready_n) begin
                if (q_n.size() == 0) check("sb_n_unexpected", 1, 0);
                else check("sb_n_prod", 32'(prod_n), 32'(q_n.pop_front()));
            end
            if (!out_valid_s) check("prod_s_zero", 32'(prod_s), 0);
            if (!out_valid_n) check("prod_n_zero", 32'(prod_n), 0);
        end
    end

    function automatic logic rdy(input int idx);
        return (idx == 0) ? in_ready_s : in_ready_n;
    endfunction

    function automatic logic ov(input int idx);
        return (idx == 0) ? out_valid_s : out_valid_n;
    endfunction

    task automatic set_in(input int idx, input logic v, input logic [7:0] av, input logic [7:0] bv);
        if (idx == 0) begin
            in_valid_s = v; a_s = av; b_s = bv;
        end else begin
            in_valid_n = v; a_n = av; b_n = bv;
        end
    endtask

    task automatic wait_out(input int idx, input string name, output int lat);
        lat = 1;
        while (!ov(idx) && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
        check(name, 32'(ov(idx)), 1);
    endtask

    task automatic run_op(input int idx, input logic [7:0] av, input logic [7:0] bv,
                          input int exp_lat);
        int lat;
        int guard;
        guard = 0;
        while (!rdy(idx) && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check("ready_before", 32'(rdy(idx)), 1);
        set_in(idx, 1'b1, av, bv);
        @(posedge clk); #1;
        set_in(idx, 1'b0, 8'($urandom), 8'($urandom));
        wait_out(idx, "out_valid_seen", lat);
        check("latency", 32'(lat), 32'(exp_lat));
        @(posedge clk); #1;
        check("ready_after", 32'(rdy(idx)), 1);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        int         lat_skip;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int lat;
        int cnt;
        int guard;
        logic [15:0] held;

        vecs[0]  = '{8'hA7, 8'h5C, 5};
        vecs[1]  = '{8'h00, 8'hFF, 1};
        vecs[2]  = '{8'h30, 8'h02, 2};
        vecs[3]  = '{8'hFF, 8'hFF, 5};
        vecs[4]  = '{8'h12, 8'h34, 5};
        vecs[5]  = '{8'h10, 8'h01, 2};
        vecs[6]  = '{8'h01, 8'h10, 2};
        vecs[7]  = '{8'hF0, 8'hF0, 2};
        vecs[8]  = '{8'h0F, 8'h0F, 2};
        vecs[9]  = '{8'h11, 8'h00, 1};
        vecs[10] = '{8'h8F, 8'hF8, 5};
        vecs[11] = '{8'h05, 8'hA0, 2};

        rst = 1'b1;
        set_in(0, 1'b0, 8'h00, 8'h00);
        set_in(1, 1'b0, 8'h00, 8'h00);
        out_ready_s = 1'b1;
        out_ready_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready_s", 32'(in_ready_s), 1);
        check("rst_out_valid_s", 32'(out_valid_s), 0);
        check("rst_busy_s", 32'(busy_s), 0);
        check("rst_prod_s", 32'(prod_s), 0);
        check("rst_in_ready_n", 32'(in_ready_n), 1);
        check("rst_busy_n", 32'(busy_n), 0);
        rst = 1'b0;

        // Spot values independent of the scoreboard.
        check("ap4_3x2_hl", 32'(mul_model(8'h30, 8'h02, 1'b1)), 32'(ap4_model(3, 2) * 16));
        check("zero_op_model", 32'(mul_model(8'h00, 8'hFF, 1'b1)), 0);

        for (int i = 0; i < 12; i++) run_op(0, vecs[i].a, vecs[i].b, vecs[i].lat_skip);
        for (int i = 0; i < 12; i++) run_op(1, vecs[i].a, vecs[i].b, 5);

        // Busy duration with all four steps executed.
        @(posedge clk); #1;
        set_in(1, 1'b1, 8'hA7, 8'h5C);
        @(posedge clk); #1;
        set_in(1, 1'b0, 8'h00, 8'h00);
        cnt = 0;
        guard = 0;
        while (busy_n && guard < 20) begin
            cnt++;
            guard++;
            @(posedge clk); #1;
        end
        check("busy_cycles", 32'(cnt), 5);

        // Backpressure: hold DONE, ignore new offers, then release.
        out_ready_s = 1'b0;
        set_in(0, 1'b1, 8'h12, 8'h34);
        @(posedge clk); #1;
        set_in(0, 1'b0, 8'h00, 8'h00);
        wait_out(0, "bp_out_valid", lat);
        held = prod_s;
        check("bp_prod_value", 32'(held), 32'(mul_model(8'h12, 8'h34, 1'b1)));
        set_in(0, 1'b1, 8'h55, 8'h66);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_prod_stable", 32'(prod_s), 32'(held));
            check("bp_in_ready_low", 32'(in_ready_s), 0);
        end
        out_ready_s = 1'b1;
        @(posedge clk); #1;
        check("bp_idle_in_ready", 32'(in_ready_s), 1);
        check("bp_idle_out_valid", 32'(out_valid_s), 0);
        @(posedge clk); #1;
        check("bp_next_accepted", 32'(in_ready_s), 0);
        set_in(0, 1'b0, 8'h00, 8'h00);
        wait_out(0, "bp_next_done", lat);
        @(posedge clk); #1;

        // Reset while in step LH discards the operation.
        set_in(1, 1'b1, 8'hA7, 8'h5C);
        @(posedge clk); #1;
        set_in(1, 1'b0, 8'h00, 8'h00);
        @(posedge clk); #1;
        check("lh_busy", 32'(busy_n), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_lh_in_ready", 32'(in_ready_n), 1);
        check("rst_lh_out_valid", 32'(out_valid_n), 0);
        check("rst_lh_prod", 32'(prod_n), 0);
        check("rst_lh_busy", 32'(busy_n), 0);
        run_op(1, 8'hFF, 8'hFF, 5);

        repeat (2) @(posedge clk);
        #1;
        check("sb_s_empty", 32'(q_s.size()), 0);
        check("sb_n_empty", 32'(q_n.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
